// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes RV32I in ID and registers ALU operands,
// opcode and control flags into the ID/EX boundary.
module alu_issue_stage #(
  parameter logic [3:0] NOP_OP = 4'b0010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [31:0] id_inst,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic [31:0] id_imm,
  input  logic        stall,
  input  logic        flush,
  output logic        ex_valid,
  output logic [31:0] ex_A,
  output logic [31:0] ex_B,
  output logic [3:0]  ex_ALU_operation,
  output logic        ex_is_branch,
  output logic        ex_br_on_zero,
  output logic        ex_reg_write,
  output logic [4:0]  ex_rd,
  output logic        ex_illegal
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1100;
  localparam logic [3:0] OP_SRL  = 4'b1101;
  localparam logic [3:0] OP_SLL  = 4'b1110;
  localparam logic [3:0] OP_SRA  = 4'b1111;

  typedef struct packed {
    logic        valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic        is_branch;
    logic        on_zero;
    logic        reg_write;
    logic [4:0]  rd;
    logic        illegal;
  } ex_t;

  localparam ex_t BUBBLE = '{
    valid:     1'b0,
    a:         32'd0,
    b:         32'd0,
    op:        NOP_OP,
    is_branch: 1'b0,
    on_zero:   1'b0,
    reg_write: 1'b0,
    rd:        5'd0,
    illegal:   1'b0
  };

  ex_t ex_d, ex_q, dec;
  logic ill;

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rd;
  logic       is_shift;
  logic       unused_rs1_field;

  assign opc      = id_inst[6:0];
  assign rd       = id_inst[11:7];
  assign f3       = id_inst[14:12];
  assign f7       = id_inst[31:25];
  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);
  assign unused_rs1_field = ^id_inst[19:15];

  function automatic logic [3:0] f3_op(input logic [2:0] f);
    logic [3:0] r;
    r = OP_ADD;
    case (f)
      3'b000:  r = OP_ADD;
      3'b001:  r = OP_SLL;
      3'b010:  r = OP_SLT;
      3'b011:  r = OP_SLTU;
      3'b100:  r = OP_XOR;
      3'b101:  r = OP_SRL;
      3'b110:  r = OP_OR;
      default: r = OP_AND;
    endcase
    return r;
  endfunction

  logic is_op, is_opi, is_load, is_store;
  logic is_br, is_lui, is_auipc, is_jmp;

  assign is_op    = (opc == 7'b0110011);
  assign is_opi   = (opc == 7'b0010011);
  assign is_load  = (opc == 7'b0000011);
  assign is_store = (opc == 7'b0100011);
  assign is_br    = (opc == 7'b1100011);
  assign is_lui   = (opc == 7'b0110111);
  assign is_auipc = (opc == 7'b0010111);
  assign is_jmp   = (opc == 7'b1101111) ||
                    (opc == 7'b1100111);

  always_comb begin
    dec       = BUBBLE;
    dec.valid = 1'b1;
    dec.rd    = rd;
    ill       = 1'b0;
    unique case (1'b1)
      is_op: begin
        dec.a         = id_rs1_data;
        dec.b         = id_rs2_data;
        dec.op        = f3_op(f3);
        dec.reg_write = 1'b1;
        if (f7 == 7'b0100000) begin
          if (f3 == 3'b000)      dec.op = OP_SUB;
          else if (f3 == 3'b101) dec.op = OP_SRA;
          else                   ill    = 1'b1;
        end else if (f7 != 7'b0000000) begin
          ill = 1'b1;
        end
        if (is_shift) dec.b = {27'b0, id_rs2_data[4:0]};
      end
      is_opi: begin
        dec.a         = id_rs1_data;
        dec.b         = id_imm;
        dec.op        = f3_op(f3);
        dec.reg_write = 1'b1;
        if (is_shift) begin
          dec.b = {27'b0, id_inst[24:20]};
          if (f3 == 3'b101 && f7 == 7'b0100000)
            dec.op = OP_SRA;
          else if (f7 != 7'b0000000)
            ill = 1'b1;
        end
      end
      is_load, is_store: begin
        dec.a         = id_rs1_data;
        dec.b         = id_imm;
        dec.op        = OP_ADD;
        dec.reg_write = is_load;
      end
      is_br: begin
        dec.a         = id_rs1_data;
        dec.b         = id_rs2_data;
        dec.is_branch = 1'b1;
        case (f3)
          3'b000: begin dec.op = OP_SUB;  dec.on_zero = 1'b1; end
          3'b001: begin dec.op = OP_SUB;  dec.on_zero = 1'b0; end
          3'b100: begin dec.op = OP_SLT;  dec.on_zero = 1'b0; end
          3'b101: begin dec.op = OP_SLT;  dec.on_zero = 1'b1; end
          3'b110: begin dec.op = OP_SLTU; dec.on_zero = 1'b0; end
          3'b111: begin dec.op = OP_SLTU; dec.on_zero = 1'b1; end
          default: ill = 1'b1;
        endcase
      end
      is_lui: begin
        dec.b         = id_imm;
        dec.op        = OP_ADD;
        dec.reg_write = 1'b1;
      end
      is_auipc: begin
        dec.a         = id_pc;
        dec.b         = id_imm;
        dec.op        = OP_ADD;
        dec.reg_write = 1'b1;
      end
      is_jmp: begin
        dec.a         = id_pc;
        dec.b         = 32'd4;
        dec.op        = OP_ADD;
        dec.reg_write = 1'b1;
      end
      default: ill = 1'b1;
    endcase
    // Illegal encodings travel down as a tagged, side-effect-free slot
    if (ill) begin
      dec.a         = 32'd0;
      dec.b         = 32'd0;
      dec.op        = NOP_OP;
      dec.is_branch = 1'b0;
      dec.on_zero   = 1'b0;
      dec.reg_write = 1'b0;
      dec.illegal   = 1'b1;
    end
    if (rd == 5'd0) dec.reg_write = 1'b0;
  end

  always_comb begin
    ex_d = ex_q;
    if (flush)       ex_d = BUBBLE;
    else if (!stall) ex_d = id_valid ? dec : BUBBLE;
  end

  always_ff @(posedge clk) begin
    if (rst) ex_q <= BUBBLE;
    else     ex_q <= ex_d;
  end

  assign ex_valid         = ex_q.valid;
  assign ex_A             = ex_q.a;
  assign ex_B             = ex_q.b;
  assign ex_ALU_operation = ex_q.op;
  assign ex_is_branch     = ex_q.is_branch;
  assign ex_br_on_zero    = ex_q.on_zero;
  assign ex_reg_write     = ex_q.reg_write;
  assign ex_rd            = ex_q.rd;
  assign ex_illegal       = ex_q.illegal;

endmodule
